// File: rtl/i2s_pkg.sv
// Shared I2S definitions, identical on the transmit and receive side.
// Holds the bus constants (word-select encoding, slot length), counter
// widths, and the sck-fall / sample-load decode so both directions agree
// bit-for-bit on frame timing.
package i2s_pkg;

    localparam logic WS_LEFT   = 1'b0;
    localparam logic WS_RIGHT  = 1'b1;
    localparam int   SLOT_BITS = 32;
    localparam int   PRESC_W   = 8;
    localparam int   BITCTR_W  = 5;

    // fall : sck is about to go 1->0 on this clk
    // load : the shift register takes a new slot word on this clk
    // slot : word-select value of the slot being loaded
    typedef struct packed {
        logic fall;
        logic load;
        logic slot;
    } i2s_evt_t;

    // Left-justified loads at the 31->0 wrap, so the slot is the ws value
    // about to be driven. I2S loads one sck later (0->1), inside the slot
    // that ws already names.
    function automatic i2s_evt_t i2s_decode(
        input logic                en,
        input logic [PRESC_W-1:0]  presc,
        input logic                sck,
        input logic [BITCTR_W-1:0] bit_ctr,
        input logic                ws,
        input logic                left_justified
    );
        i2s_evt_t e;
        e.fall = en && (presc == '0) && sck;
        if (left_justified) begin
            e.load = e.fall && (bit_ctr == BITCTR_W'(SLOT_BITS - 1));
            e.slot = ~ws;
        end else begin
            e.load = e.fall && (bit_ctr == '0);
            e.slot = ws;
        end
        return e;
    endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous fall-through FIFO feeding the I2S transmitter.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (contents discarded)
//   wr_i, wdata_i   push request and data
//   rd_i            pop request; rdata_o always shows the head word
//   full_o/empty_o  exact occupancy flags
//   level_o         occupancy 0..2**AW
// Push/pop semantics: a push is accepted when not full, or when full and a
// pop is accepted on the same clk; a pop is accepted only when not empty.
// Rejected requests leave all state unchanged.
module i2s_tx_fifo #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rd_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_wr, do_rd;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_rd = rd_i && !empty_o;
    assign do_wr = wr_i && (!full_o || do_rd);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_wr) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_rd) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/i2s_tx_master.sv
// FIFO-fed I2S master transmitter.
// Generates sck/ws from clk and serialises right-aligned FIFO samples onto
// sdo, MSB first, 32 sck per slot, ws=0 left / ws=1 right.
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   sck, ws, sdo            I2S bus outputs (sdo changes with sck falling)
//   fifo_wr, fifo_wdata     sample push
//   fifo_level_threshold    compare value for fifo_level_below
//   fifo_full/empty/level   FIFO status
//   fifo_level_below        fifo_level < fifo_level_threshold
//   underrun                1-clk pulse when an enabled slot found no data
//   left_justified          1 = MSB on the ws edge, 0 = I2S one-sck delay
//   sample_size             bits per sample, 0 means 32
//   sck_prescaler           sck half-period minus one, in clk cycles
//   channels                [1] left enable, [0] right enable
//   en                      run timing/serialiser; 0 freezes the bus
module i2s_tx_master
    import i2s_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               sck,
    output logic               ws,
    output logic               sdo,
    input  logic               fifo_wr,
    input  logic [31:0]        fifo_wdata,
    input  logic [AW:0]        fifo_level_threshold,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [AW:0]        fifo_level,
    output logic               fifo_level_below,
    output logic               underrun,
    input  logic               left_justified,
    input  logic [4:0]         sample_size,
    input  logic [PRESC_W-1:0] sck_prescaler,
    input  logic [1:0]         channels,
    input  logic               en
);

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [BITCTR_W-1:0] bit_ctr_q, bit_ctr_d;
    logic                sck_q, sck_d;
    logic                ws_q, ws_d;
    logic                sdo_q, sdo_d;
    logic                underrun_q, underrun_d;
    logic                synced_q, synced_d;
    logic [31:0]         shift_q, shift_d;

    i2s_evt_t            ev;
    logic                slot_en;
    logic                fifo_rd;
    logic [31:0]         fifo_rdata;
    logic [4:0]          shamt;

    // Left-align the sample: 32 - size, where size 0 (=32) needs no shift.
    assign shamt = 5'd0 - sample_size;

    assign ev = i2s_decode(en, presc_q, sck_q, bit_ctr_q, ws_q, left_justified);

    i2s_tx_fifo #(
        .DW (32),
        .AW (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_i    (fifo_wr),
        .wdata_i (fifo_wdata),
        .rd_i    (fifo_rd),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        presc_d    = presc_q;
        sck_d      = sck_q;
        ws_d       = ws_q;
        bit_ctr_d  = bit_ctr_q;
        shift_d    = shift_q;
        synced_d   = synced_q;
        underrun_d = 1'b0;
        fifo_rd    = 1'b0;
        slot_en    = 1'b0;

        if (!en) begin
            synced_d = 1'b0;
        end else if (presc_q == '0) begin
            presc_d = sck_prescaler;
            sck_d   = ~sck_q;
        end else begin
            presc_d = presc_q - 1'b1;
        end

        if (ev.fall) begin
            bit_ctr_d = bit_ctr_q + 1'b1;
            shift_d   = shift_q << 1;
            if (bit_ctr_q == BITCTR_W'(SLOT_BITS - 1)) begin
                ws_d = ~ws_q;
            end
        end

        // A load overrides the shift taken on the same fall. The first left
        // load is itself allowed to pop, so stereo pairs always start on L.
        if (ev.load) begin
            slot_en = (ev.slot == WS_LEFT) ? channels[1] : channels[0];
            if (ev.slot == WS_LEFT) begin
                synced_d = 1'b1;
            end
            shift_d = '0;
            if (slot_en && (synced_q || (ev.slot == WS_LEFT))) begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    shift_d = fifo_rdata << shamt;
                end else begin
                    underrun_d = 1'b1;
                end
            end
        end

        sdo_d = shift_d[31];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            bit_ctr_q  <= '0;
            sck_q      <= 1'b0;
            ws_q       <= WS_RIGHT;
            sdo_q      <= 1'b0;
            underrun_q <= 1'b0;
            synced_q   <= 1'b0;
            shift_q    <= '0;
        end else begin
            presc_q    <= presc_d;
            bit_ctr_q  <= bit_ctr_d;
            sck_q      <= sck_d;
            ws_q       <= ws_d;
            sdo_q      <= sdo_d;
            underrun_q <= underrun_d;
            synced_q   <= synced_d;
            shift_q    <= shift_d;
        end
    end

    assign sck              = sck_q;
    assign ws               = ws_q;
    assign sdo              = sdo_q;
    assign underrun         = underrun_q;
    assign fifo_level_below = (fifo_level < fifo_level_threshold);

endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: FIFO bound table, per-clk frame model, hand
// sequences for the multi-cycle corners, randomized runs.
module tb_i2s_tx_master;

    logic        clk;
    logic        rst_n;
    logic        sck, ws, sdo;
    logic        fifo_wr;
    logic [31:0] fifo_wdata;
    logic [5:0]  fifo_level_threshold;
    logic        fifo_full, fifo_empty;
    logic [5:0]  fifo_level;
    logic        fifo_level_below;
    logic        underrun;
    logic        left_justified;
    logic [4:0]  sample_size;
    logic [7:0]  sck_prescaler;
    logic [1:0]  channels;
    logic        en;

    int total;
    int bad;

    logic [31:0] init_q[$];
    logic [31:0] obs [16];
    int          und_cnt;

    typedef struct {
        int         n_push;
        logic [5:0] thr;
        logic [5:0] lvl;
        logic       full;
        logic       empty;
        logic       below;
    } fvec_t;

    fvec_t fv [8];

    i2s_tx_master #(.AW(5)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .sck                  (sck),
        .ws                   (ws),
        .sdo                  (sdo),
        .fifo_wr              (fifo_wr),
        .fifo_wdata           (fifo_wdata),
        .fifo_level_threshold (fifo_level_threshold),
        .fifo_full            (fifo_full),
        .fifo_empty           (fifo_empty),
        .fifo_level           (fifo_level),
        .fifo_level_below     (fifo_level_below),
        .underrun             (underrun),
        .left_justified       (left_justified),
        .sample_size          (sample_size),
        .sck_prescaler        (sck_prescaler),
        .channels             (channels),
        .en                   (en)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        en      = 1'b0;
        fifo_wr = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_one(input logic [31:0] w);
        fifo_wr    = 1'b1;
        fifo_wdata = w;
        @(posedge clk);
        @(negedge clk);
        fifo_wr = 1'b0;
    endtask

    // Sample placed MSB-first in the 32-bit slot, bits beyond size zero.
    function automatic logic [31:0] justify(input logic [31:0] w, input logic [4:0] sz);
        logic [31:0] r;
        int          n;
        r = '0;
        n = (sz == 0) ? 32 : int'(sz);
        for (int i = 0; i < n; i++) r[31-i] = w[n-1-i];
        return r;
    endfunction

    // Reference model: after clk edge n of the run, the number of sck toggles
    // is (n-1)/h+1, every second one is a fall; fall count g gives slot g/32
    // and bit g%32. Slot s>=1 takes a word at its load fall if enabled.
    task automatic run_frames(input int p, input logic lj, input logic [4:0] sz,
                              input logic [1:0] ch, input int ns,
                              input int push_edge, input logic [31:0] push_word);
        int          h, n_edges, t, f, s, b, q_before;
        logic        fall_now, und_e, popped, ws_e, sdo_e;
        logic [31:0] exp_q[$];
        logic [31:0] sb [16];
        logic [12:0] got, exp;

        h = p + 1;
        exp_q = {};
        foreach (init_q[i]) begin
            push_one(init_q[i]);
            if (exp_q.size() < 32) exp_q.push_back(init_q[i]);
        end
        for (int i = 0; i < 16; i++) begin
            sb[i]  = '0;
            obs[i] = '0;
        end
        und_cnt              = 0;
        fifo_level_threshold = 6'd4;
        sck_prescaler        = p[7:0];
        left_justified       = lj;
        sample_size          = sz;
        channels             = ch;
        en                   = 1'b1;
        n_edges              = h * (64 * ns - 2);

        for (int n = 1; n <= n_edges; n++) begin
            if (n == push_edge) begin
                fifo_wr    = 1'b1;
                fifo_wdata = push_word;
            end
            @(posedge clk);
            t = (n - 1) / h + 1;
            f = t / 2;
            s = f / 32;
            b = f % 32;
            fall_now = ((n - 1) % h == 0) && (t % 2 == 0);
            und_e    = 1'b0;
            popped   = 1'b0;
            q_before = exp_q.size();
            if (fall_now && s >= 1 && (lj ? (b == 0) : (b == 1))) begin
                if ((s % 2 == 1) ? ch[1] : ch[0]) begin
                    if (exp_q.size() > 0) begin
                        sb[s]  = justify(exp_q.pop_front(), sz);
                        popped = 1'b1;
                    end else begin
                        und_e = 1'b1;
                    end
                end
            end
            if (n == push_edge && (q_before < 32 || popped)) exp_q.push_back(push_word);
            @(negedge clk);
            fifo_wr = 1'b0;

            ws_e = (s % 2 == 0);
            if (f == 0)      sdo_e = 1'b0;
            else if (lj)     sdo_e = sb[s][31-b];
            else if (b == 0) sdo_e = sb[s-1][0];
            else             sdo_e = sb[s][32-b];

            exp = {t[0], ws_e, sdo_e, und_e, exp_q.size() == 32, exp_q.size() == 0,
                   exp_q.size() < 4, 6'(exp_q.size())};
            got = {sck, ws, sdo, underrun, fifo_full, fifo_empty, fifo_level_below, fifo_level};
            check($sformatf("frame@%0d", n), 32'(got), 32'(exp));

            if (fall_now) obs[s][31-b] = sdo;
            if (underrun === 1'b1) und_cnt++;
        end
        en = 1'b0;
    endtask

    initial begin
        total                = 0;
        bad                  = 0;
        rst_n                = 1'b0;
        en                   = 1'b0;
        fifo_wr              = 1'b0;
        fifo_wdata           = '0;
        fifo_level_threshold = 6'd4;
        left_justified       = 1'b1;
        sample_size          = 5'd0;
        sck_prescaler        = 8'd3;
        channels             = 2'b11;

        // reset state
        do_reset();
        check("reset_state", 32'({sck, ws, sdo, underrun, fifo_empty, fifo_full, fifo_level}),
              32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0}));

        // FIFO bounds and threshold table
        fv[0] = '{0,  6'd4,  6'd0,  1'b0, 1'b1, 1'b1};
        fv[1] = '{3,  6'd4,  6'd3,  1'b0, 1'b0, 1'b1};
        fv[2] = '{4,  6'd4,  6'd4,  1'b0, 1'b0, 1'b0};
        fv[3] = '{5,  6'd4,  6'd5,  1'b0, 1'b0, 1'b0};
        fv[4] = '{31, 6'd32, 6'd31, 1'b0, 1'b0, 1'b1};
        fv[5] = '{32, 6'd4,  6'd32, 1'b1, 1'b0, 1'b0};
        fv[6] = '{33, 6'd4,  6'd32, 1'b1, 1'b0, 1'b0};
        fv[7] = '{33, 6'd33, 6'd32, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            do_reset();
            fifo_level_threshold = fv[i].thr;
            for (int k = 0; k < fv[i].n_push; k++) push_one($urandom);
            check($sformatf("fifo_vec%0d", i),
                  32'({fifo_full, fifo_empty, fifo_level_below, fifo_level}),
                  32'({fv[i].full, fv[i].empty, fv[i].below, fv[i].lvl}));
        end

        // reset in the middle of a left slot (bit_ctr = 17)
        do_reset();
        push_one(32'h0000A5A5);
        push_one(32'h00001234);
        left_justified = 1'b1;
        sample_size    = 5'd16;
        channels       = 2'b11;
        sck_prescaler  = 8'd3;
        en             = 1'b1;
        repeat (1 + 4 * 97) @(posedge clk);
        @(negedge clk);
        check("pre_reset", 32'({ws, fifo_level}), 32'({1'b0, 6'd1}));
        rst_n = 1'b0;
        #1;
        check("mid_reset", 32'({sck, ws, sdo, underrun, fifo_empty, fifo_level}),
              32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0}));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;

        // left-justified stereo after the reset
        init_q = '{32'h0000A5A5, 32'h00001234};
        run_frames(3, 1'b1, 5'd16, 2'b11, 3, 0, 32'h0);
        check("lj_left_slot", obs[1], 32'hA5A5_0000);
        check("lj_right_slot", obs[2], 32'h1234_0000);

        // I2S mode, 32-bit samples
        do_reset();
        init_q = '{32'h8000_0001, 32'hFFFF_FFFF};
        run_frames(1, 1'b0, 5'd0, 2'b11, 3, 0, 32'h0);
        check("i2s_left_slot", obs[1], 32'h4000_0000);
        check("i2s_lsb_in_right_bit0", 32'(obs[2][31]), 32'd1);
        check("i2s_right_slot", obs[2], 32'hFFFF_FFFF);

        // mono left, one word then underrun
        do_reset();
        init_q = '{32'hDEAD_BEEF};
        run_frames(0, 1'b1, 5'd0, 2'b10, 4, 0, 32'h0);
        check("mono_left1", obs[1], 32'hDEAD_BEEF);
        check("mono_right", obs[2], 32'h0);
        check("mono_left2", obs[3], 32'h0);
        check("mono_underruns", 32'(und_cnt), 32'd1);

        // push on the same clk as a load into an empty FIFO
        do_reset();
        init_q = {};
        run_frames(0, 1'b1, 5'd16, 2'b11, 3, 64, 32'h0000_CAFE);
        check("empty_load_left", obs[1], 32'h0);
        check("empty_load_right", obs[2], 32'hCAFE_0000);
        check("empty_load_underruns", 32'(und_cnt), 32'd1);

        // push and pop on the same clk while full
        do_reset();
        init_q = {};
        for (int i = 0; i < 32; i++) init_q.push_back($urandom);
        run_frames(0, 1'b1, 5'd0, 2'b11, 3, 64, 32'h1357_9BDF);

        // randomized configurations
        for (int r = 0; r < 6; r++) begin
            int p;
            p = $urandom_range(0, 3);
            do_reset();
            init_q = {};
            for (int i = 0, n = $urandom_range(0, 8); i < n; i++) init_q.push_back($urandom);
            run_frames(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       2'($urandom_range(0, 3)), 5,
                       $urandom_range(1, (p + 1) * 64 * 3), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
